// File: rtl/mux8_pkg.sv
// Shared constants for the registered 8:1 lane-wise selector.
package mux8_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_D = 3'd3;
  localparam logic [2:0] SEL_E = 3'd4;
  localparam logic [2:0] SEL_F = 3'd5;
  localparam logic [2:0] SEL_G = 3'd6;
  localparam logic [2:0] SEL_H = 3'd7;

endpackage

// File: rtl/mux2_cell.sv
// 2:1 lane-wise selector cell; purely combinational, no backpressure.
module mux2_cell
  import mux8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux8_reg.sv
// Registered 8:1 lane-wise selector built from a three-level 2:1 tree.
// One cycle latency; accepts a word every cycle, no backpressure.
module mux8_reg
  import mux8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] ab_y, cd_y, ef_y, gh_y;
  logic [WIDTH-1:0] lo_y, hi_y, sel_y;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;

  mux2_cell #(.WIDTH(WIDTH)) u_ab (.in0(a), .in1(b), .sel(s0), .y(ab_y));
  mux2_cell #(.WIDTH(WIDTH)) u_cd (.in0(c), .in1(d), .sel(s0), .y(cd_y));
  mux2_cell #(.WIDTH(WIDTH)) u_ef (.in0(e), .in1(f), .sel(s0), .y(ef_y));
  mux2_cell #(.WIDTH(WIDTH)) u_gh (.in0(g), .in1(h), .sel(s0), .y(gh_y));

  mux2_cell #(.WIDTH(WIDTH)) u_lo (.in0(ab_y), .in1(cd_y), .sel(s1), .y(lo_y));
  mux2_cell #(.WIDTH(WIDTH)) u_hi (.in0(ef_y), .in1(gh_y), .sel(s1), .y(hi_y));

  mux2_cell #(.WIDTH(WIDTH)) u_top (.in0(lo_y), .in1(hi_y), .sel(s2), .y(sel_y));

  // Data holds when idle; only the valid flag drops.
  always_comb begin
    out_d = out_q;
    vld_d = in_valid;
    if (in_valid) begin
      out_d = sel_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_mux8_reg.sv
// Bench for mux8_reg: directed scenarios plus random traffic against a word-level model.
module tb_mux8_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, c, d, e, f, g, h;
  logic       s0, s1, s2;
  logic       in_valid;
  logic [3:0] out;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_out;
  logic       exp_vld;

  mux8_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .s0(s0), .s1(s1), .s2(s2),
    .in_valid(in_valid),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic set_sel(input logic [2:0] v);
    s0 = v[0];
    s1 = v[1];
    s2 = v[2];
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: word chosen by the select code, captured one edge later.
  task automatic cyc();
    logic [3:0] words [8];
    logic [2:0] sel;
    words = '{a, b, c, d, e, f, g, h};
    sel   = {s2, s1, s0};
    @(posedge clk);
    if (rst) begin
      exp_out = 4'h0;
      exp_vld = 1'b0;
    end else if (in_valid) begin
      exp_out = words[sel];
      exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1;
    {a, b, c, d, e, f, g, h} = '0;
    set_sel(3'd0);
    exp_out = 4'h0; exp_vld = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("reset_out", out, 4'h0);
    chk("reset_vld", {3'b0, out_valid}, 4'h0);

    // Select sweep
    rst = 1'b0;
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4; e = 4'd5; f = 4'd6; g = 4'd7; h = 4'd8;
    for (int i = 0; i < 8; i++) begin
      set_sel(i[2:0]);
      cyc();
      chk($sformatf("sweep_out_%0d", i), out, 4'(i + 1));
      chk($sformatf("sweep_vld_%0d", i), {3'b0, out_valid}, 4'h1);
    end

    // Lane independence
    a = 4'b0101; b = 4'b1010; {c, d, e, f, g, h} = '0;
    for (int i = 0; i < 6; i++) begin
      set_sel({2'b00, i[0]});
      cyc();
      chk($sformatf("lane_out_%0d", i), out, (i % 2 == 1) ? 4'b1010 : 4'b0101);
    end

    // Half select
    {a, b, c, d} = '0; {e, f, g, h} = {4{4'hF}};
    for (int i = 0; i < 10; i++) begin
      logic [2:0] sv;
      sv = 3'($urandom_range(0, 7));
      if (i == 0) sv[2] = 1'b0;
      if (i == 1) sv[2] = 1'b1;
      set_sel(sv);
      cyc();
      chk($sformatf("half_out_s%0d", sv), out, sv[2] ? 4'hF : 4'h0);
    end

    // Hold while idle
    set_sel(3'd3); d = 4'd9;
    cyc();
    chk("hold_cap_out", out, 4'd9);
    chk("hold_cap_vld", {3'b0, out_valid}, 4'h1);
    in_valid = 1'b0; d = 4'd2;
    cyc();
    chk("hold_out_1", out, 4'd9);
    chk("hold_vld_1", {3'b0, out_valid}, 4'h0);
    set_sel(3'd5); f = 4'd7;
    cyc();
    chk("hold_out_2", out, 4'd9);
    chk("hold_vld_2", {3'b0, out_valid}, 4'h0);

    // Reset priority over valid
    in_valid = 1'b1; set_sel(3'd7); h = 4'hF; rst = 1'b1;
    cyc();
    chk("rstpri_out", out, 4'h0);
    chk("rstpri_vld", {3'b0, out_valid}, 4'h0);
    rst = 1'b0;
    cyc();
    chk("rstrel_out", out, 4'hF);
    chk("rstrel_vld", {3'b0, out_valid}, 4'h1);

    // Random traffic against the reference
    for (int i = 0; i < 1000; i++) begin
      {a, b, c, d} = 16'($urandom);
      {e, f, g, h} = 16'($urandom);
      set_sel(3'($urandom_range(0, 7)));
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 31) == 0);
      cyc();
      chk($sformatf("rand_out_%0d", i), out, exp_out);
      chk($sformatf("rand_vld_%0d", i), {3'b0, out_valid}, {3'b0, exp_vld});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8_reg.md
MUX8_REG -- requirements
Module: mux8_reg

Interface
REQ-001 Parameter WIDTH, default 4: number of independent bit lanes; lane i of the output is selected only from lane i of the data inputs.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a, b, c, d, e, f, g, h  input  WIDTH each  data inputs 0 through 7, in that order.
REQ-005 s0, s1, s2  input  1 each  select bits; sel = {s2,s1,s0}, with s0 as the LSB.
REQ-006 in_valid  input  1  qualifies the data and select inputs for capture.
REQ-007 out  output  WIDTH  registered selected data.
REQ-008 out_valid  output  1  high when out holds data captured in the previous cycle.

Function
REQ-009 Selection shall be: sel 0->a, 1->b, 2->c, 3->d, 4->e, 5->f, 6->g, 7->h.
REQ-010 Selection shall be a three-level binary tree, one level per select bit:
  - s0 picks a/b, c/d, e/f and g/h;
  - s1 picks between the (a,b) and (c,d) results, and between the (e,f) and (g,h) results;
  - s2 picks the lower half (a-d) when 0 and the upper half (e-h) when 1.
REQ-011 Every lane shall be independent; no bit of out depends on any other lane index.
REQ-012 Latency shall be exactly 1 cycle. When in_valid=1 at a rising edge, out takes the selected value and out_valid becomes 1 after that edge.
REQ-013 When in_valid=0 at a rising edge, out holds its previous value and out_valid becomes 0.
REQ-014 There is no backpressure; a new word may be accepted every cycle, back-to-back.
REQ-015 Changes to data or select while in_valid=0 shall have no effect on out.
REQ-016 Changing sel on consecutive valid cycles shall yield the newly selected word each cycle, with no holdover from the prior selection.
REQ-017 The datapath shall be purely selection, with no arithmetic; out width equals WIDTH exactly.

Reset
REQ-018 While rst=1 at a rising edge, out shall become all-zeros and out_valid shall become 0, regardless of in_valid.
REQ-019 rst takes priority over a simultaneous in_valid=1; that word is discarded and not captured.
REQ-020 Reset asserted mid-stream clears state on the next edge; the first valid word after rst deasserts appears with the normal 1-cycle latency.
REQ-021 No output shall be undefined after the first reset edge.

Structure
REQ-022 A shared package mux8_pkg shall hold:
  - default-width constant DEF_WIDTH=4;
  - select-code constants SEL_A=0 through SEL_H=7.
REQ-023 The 2:1 selector shall be one sub-module, mux2_cell (inputs in0, in1, sel; output y, where y = sel ? in1 : in0, WIDTH-parameterized), instantiated seven times to form the tree.
REQ-024 The output register and valid flag shall reside in the top module only.

Verification
REQ-025 Select sweep: a..h = 1,2,3,4,5,6,7,8 with in_valid=1, sel stepped 0..7 on consecutive cycles -> out = 1,2,...,8 with a 1-cycle lag, out_valid=1 throughout.
REQ-026 Lane independence: a=4'b0101, b=4'b1010, other inputs 0; toggle s0 every cycle -> out alternates 0101/1010, with no other bit values.
REQ-027 Half select: e..h=4'hF, a..d=4'h0; s2=1 with any s1/s0 -> out=F; s2=0 -> out=0.
REQ-028 Hold: capture sel=3 with d=9, then in_valid=0 while d changes to 2 -> out stays 9 and out_valid=0 from the next cycle.
REQ-029 Reset priority: rst=1 together with in_valid=1, sel=7, h=F -> out=0 and out_valid=0 after the edge; release rst with the same inputs -> out=F one cycle later.
REQ-030 Random: 1000 random data/sel/in_valid/rst cycles checked against a reference model of REQ-009 and REQ-012 through REQ-019 -> zero mismatches.
